// File: rtl/psum_if.sv
// Handshake bundle between the MAC issue controller, the MAC result bus
// and the output consumer of mac_psum_acc.
interface psum_if #(
  parameter int OUT_W = 16
);
  logic                    issue;
  logic                    issue_last;
  logic signed [33:0]      mac_result;
  logic                    issue_ok;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    overflow;

  modport master (
    output issue, issue_last, mac_result, out_ready,
    input  issue_ok, out_valid, out_data, overflow
  );

  modport slave (
    input  issue, issue_last, mac_result, out_ready,
    output issue_ok, out_valid, out_data, overflow
  );
endinterface

// File: rtl/mac_psum_acc.sv
// Partial-sum accumulator behind the non-stallable MAC: a tag delay line
// aligns each result with its issue, and finals are scaled, clamped and queued.
// The sums are queued under issue credit. Define PSUM_RELU_EN to zero negative
// finals before saturation.
module mac_psum_acc #(
  parameter int LAT        = 4,
  parameter int ACC_W      = 40,
  parameter int SHIFT      = 0,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic   clk,
  input logic   rst,
  psum_if.slave psum_io
);
  localparam int MAC_W = 34;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW    = $clog2(LAT + 1);
  localparam int CW    = PW + IW + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [LAT:1]            vld_pipe_q, lst_pipe_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_q, rd_q;
  logic [PW:0]             count_q, count_d;
  logic                    ovf_q;

  logic                    tv, tl, push, pop, full, wr_en;
  logic signed [ACC_W-1:0] x, sum, f;
  logic [OUT_W-1:0]        res;
  logic [IW-1:0]           inflight;

  assign tv = vld_pipe_q[LAT];
  assign tl = lst_pipe_q[LAT];

  // Tags only; results themselves arrive on mac_result and are never stored here.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= psum_io.issue;
      lst_pipe_q[1] <= psum_io.issue & psum_io.issue_last;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        lst_pipe_q[i] <= lst_pipe_q[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= LAT; i++) inflight = inflight + IW'(lst_pipe_q[i]);
  end

  always_comb begin
    x       = {{(ACC_W-MAC_W){psum_io.mac_result[MAC_W-1]}}, psum_io.mac_result};
    sum     = first_q ? x : acc_q + x;
    f       = sum >>> SHIFT;
`ifdef PSUM_RELU_EN
    if (f[ACC_W-1]) f = '0;
`endif
    if (f > SAT_MAX)      res = SAT_MAX[OUT_W-1:0];
    else if (f < SAT_MIN) res = SAT_MIN[OUT_W-1:0];
    else                  res = f[OUT_W-1:0];
    acc_d   = acc_q;
    first_d = first_q;
    if (tv) begin
      acc_d   = sum;
      first_d = tl;
    end
  end

  assign push  = tv & tl;
  assign pop   = psum_io.out_valid & psum_io.out_ready;
  assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the head slot, which is exactly wr_q.
  assign wr_en = push & (~full | pop);

  always_comb begin
    count_d = count_q;
    if (wr_en & ~pop)      count_d = count_q + 1'b1;
    else if (~wr_en & pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      first_q <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      first_q <= first_d;
      count_q <= count_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (push & full & ~pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= res;
  end

  assign psum_io.out_valid = (count_q != '0);
  assign psum_io.out_data  = psum_io.out_valid ? mem_q[rd_q] : '0;
  assign psum_io.overflow  = ovf_q;
  assign psum_io.issue_ok  = (CW'(count_q) + CW'(inflight)) < CW'(FIFO_DEPTH);
endmodule

// File: tb/tb_mac_psum_acc.sv
// Directed bench for mac_psum_acc: SHIFT=0 and SHIFT=4 instances share stimulus.
module tb_mac_psum_acc;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_if #(.OUT_W(16)) b0();
  psum_if #(.OUT_W(16)) b4();

  logic signed [33:0] res_in;
  logic signed [33:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= res_in;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  assign b0.mac_result = rpipe[LAT-1];
  assign b4.mac_result = rpipe[LAT-1];
  assign b4.issue      = b0.issue;
  assign b4.issue_last = b0.issue_last;
  assign b4.out_ready  = b0.out_ready;

  mac_psum_acc #(.LAT(LAT), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .psum_io(b0.slave));
  mac_psum_acc #(.LAT(LAT), .SHIFT(4)) dut4 (.clk(clk), .rst(rst), .psum_io(b4.slave));

  int checks = 0;
  int passes = 0;

  task automatic do_issue(input logic last, input int v);
    b0.issue      = 1'b1;
    b0.issue_last = last;
    res_in        = 34'(v);
    @(negedge clk);
    b0.issue      = 1'b0;
    b0.issue_last = 1'b0;
    res_in        = '0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; b0.issue = 1'b0; b0.issue_last = 1'b0; b0.out_ready = 1'b0; res_in = '0;
    wait_n(3);
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", b0.out_valid); else passes++;
    checks++; if (b0.out_data !== 16'sd0) $display("FAIL rst_data got %0d want 0", b0.out_data); else passes++;
    checks++; if (b0.overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", b0.overflow); else passes++;
    checks++; if (b0.issue_ok !== 1'b1) $display("FAIL rst_issue_ok got %b want 1", b0.issue_ok); else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    b0.out_ready = 1'b1;
    do_issue(1'b1, 1000);
    wait_n(LAT - 1);
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL single_early got %b want 0", b0.out_valid); else passes++;
    @(negedge clk);
    checks++; if (b0.out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", b0.out_valid); else passes++;
    checks++; if (b0.out_data !== 16'sd1000) $display("FAIL single_data got %0d want 1000", b0.out_data); else passes++;
    @(negedge clk);
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL single_popped got %b want 0", b0.out_valid); else passes++;
  endtask

  task automatic test_shift;
    b0.out_ready = 1'b1;
    do_issue(1'b1, 1024);
    wait_n(LAT);
    checks++; if (b0.out_data !== 16'sd1024) $display("FAIL shift0_data got %0d want 1024", b0.out_data); else passes++;
    checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== 16'sd64)
      $display("FAIL shift4_data got %b/%0d want 1/64", b4.out_valid, b4.out_data); else passes++;
    @(negedge clk);
  endtask

  task automatic test_multi_group;
    int early;
    early = 0;
    b0.out_ready = 1'b1;
    do_issue(1'b0, 100);
    do_issue(1'b0, -50);
    do_issue(1'b1, 25);
    for (int i = 0; i < LAT; i++) begin
      if (b0.out_valid === 1'b1) early++;
      @(negedge clk);
    end
    checks++; if (early !== 0) $display("FAIL multi_early got %0d outputs want 0", early); else passes++;
    checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 16'sd75)
      $display("FAIL multi_data got %b/%0d want 1/75", b0.out_valid, b0.out_data); else passes++;
    @(negedge clk);
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL multi_once got %b want 0", b0.out_valid); else passes++;
  endtask

  task automatic test_saturation;
    int v   [3] = '{40000, -40000, -5};
`ifdef PSUM_RELU_EN
    int exp [3] = '{32767, 0, 0};
`else
    int exp [3] = '{32767, -32768, -5};
`endif
    b0.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_issue(1'b1, v[k]);
      wait_n(LAT);
      checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 16'(exp[k]))
        $display("FAIL sat_%0d got %b/%0d want 1/%0d", v[k], b0.out_valid, b0.out_data, exp[k]); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    b0.out_ready = 1'b0;
    checks++; if (b0.issue_ok !== 1'b1) $display("FAIL bp_ok_start got %b want 1", b0.issue_ok); else passes++;
    for (int k = 1; k <= 3; k++) do_issue(1'b1, k);
    checks++; if (b0.issue_ok !== 1'b1) $display("FAIL bp_ok_3 got %b want 1", b0.issue_ok); else passes++;
    do_issue(1'b1, 4);
    checks++; if (b0.issue_ok !== 1'b0) $display("FAIL bp_ok_4 got %b want 0", b0.issue_ok); else passes++;
    wait_n(LAT);
    checks++; if (b0.issue_ok !== 1'b0) $display("FAIL bp_ok_full got %b want 0", b0.issue_ok); else passes++;
    checks++; if (b0.overflow !== 1'b0) $display("FAIL bp_ovf got %b want 0", b0.overflow); else passes++;
    b0.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 16'(k))
        $display("FAIL bp_drain_%0d got %b/%0d want 1/%0d", k, b0.out_valid, b0.out_data, k); else passes++;
      @(negedge clk);
      if (k == 1) begin
        checks++; if (b0.issue_ok !== 1'b1) $display("FAIL bp_ok_after_pop got %b want 1", b0.issue_ok); else passes++;
      end
    end
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", b0.out_valid); else passes++;
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    b0.out_ready = 1'b1;
    do_issue(1'b0, 500);
    do_issue(1'b0, 500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (b0.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) $display("FAIL rmid_no_out got %0d outputs want 0", seen); else passes++;
    do_issue(1'b1, 7);
    wait_n(LAT);
    checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 16'sd7)
      $display("FAIL rmid_fresh got %b/%0d want 1/7", b0.out_valid, b0.out_data); else passes++;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int exp_a [5] = '{11, 12, 13, 14, 55};
    b0.out_ready = 1'b0;
    for (int k = 11; k <= 14; k++) do_issue(1'b1, k);
    wait_n(LAT);
    // Push into a full FIFO while the head pops in the same cycle.
    do_issue(1'b1, 55);
    wait_n(LAT - 1);
    b0.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 16'(exp_a[k]))
        $display("FAIL fullpp_%0d got %b/%0d want 1/%0d", k, b0.out_valid, b0.out_data, exp_a[k]); else passes++;
      @(negedge clk);
    end
    checks++; if (b0.out_valid !== 1'b0 || b0.overflow !== 1'b0)
      $display("FAIL fullpp_end got valid %b ovf %b want 0 0", b0.out_valid, b0.overflow); else passes++;

    b0.out_ready = 1'b0;
    for (int k = 21; k <= 24; k++) do_issue(1'b1, k);
    wait_n(LAT);
    checks++; if (b0.issue_ok !== 1'b0) $display("FAIL ovf_ok got %b want 0", b0.issue_ok); else passes++;
    do_issue(1'b1, 99);
    wait_n(LAT);
    checks++; if (b0.overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", b0.overflow); else passes++;
    wait_n(3);
    checks++; if (b0.overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", b0.overflow); else passes++;
    b0.out_ready = 1'b1;
    for (int k = 21; k <= 24; k++) begin
      checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 16'(k))
        $display("FAIL ovf_drain_%0d got %b/%0d want 1/%0d", k, b0.out_valid, b0.out_data, k); else passes++;
      @(negedge clk);
    end
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL ovf_no_extra got %b want 0", b0.out_valid); else passes++;
    checks++; if (b0.overflow !== 1'b1) $display("FAIL ovf_hold got %b want 1", b0.overflow); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (b0.overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", b0.overflow); else passes++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_shift;
    test_multi_group;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    test_overflow;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
